// File: rtl/fsmd_1010_pkg.sv
// Shared definitions for the 1010-preamble FSMD serial link (transmit and receive sides).
package fsmd_1010_pkg;

   localparam int PRE_W   = 4;
   localparam int DATA_W  = 16;
   localparam int FRAME_W = PRE_W + DATA_W;
   localparam logic [PRE_W-1:0] PREAMBLE = 4'b1010;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PRE  = 2'd1,
      S_DATA = 2'd2,
      S_PAR  = 2'd3
   } state_t;

   // Width of a down-counter that must hold n-1.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fsmd_1010_tx_if.sv
// Frame request / serial output bundle of the 1010-preamble transmitter.
interface fsmd_1010_tx_if #(
   parameter int DATA_W = fsmd_1010_pkg::DATA_W
);
   logic              start;
   logic [DATA_W-1:0] data_in;
   logic              d_out;
   logic              frame;
   logic              busy;
   logic              done;

   modport master (
      output start, data_in,
      input  d_out, frame, busy, done
   );

   modport slave (
      input  start, data_in,
      output d_out, frame, busy, done
   );
endinterface

// File: rtl/fsmd_1010_shreg.sv
// Loadable left shift register with a saturating down-counter marking the last bit.
module fsmd_1010_shreg #(
   parameter int FRAME_W = fsmd_1010_pkg::FRAME_W,
   parameter int CNT_W   = fsmd_1010_pkg::cnt_width(fsmd_1010_pkg::FRAME_W)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               load,
   input  logic               shift,
   input  logic [FRAME_W-1:0] load_word,
   output logic               out_bit,
   output logic [CNT_W-1:0]   count,
   output logic               last
);

   logic [FRAME_W-1:0] sh_reg;
   logic [FRAME_W-1:0] sh_next;
   logic [FRAME_W-1:0] shifted;
   logic [CNT_W-1:0]   cnt_reg;

   genvar gi;
   generate
      for (gi = 0; gi < FRAME_W; gi++) begin : g_bit
         if (gi == 0) begin : g_lsb
            assign shifted[gi] = 1'b0;
         end else begin : g_upper
            assign shifted[gi] = sh_reg[gi-1];
         end
      end
   endgenerate

   always_comb begin
      sh_next = sh_reg;
      if (load) begin
         sh_next = load_word;
      end else if (shift) begin
         sh_next = shifted;
      end
   end

   // Counter holds the number of bits still to follow the one on the line.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sh_reg  <= '0;
         cnt_reg <= '0;
      end else begin
         sh_reg <= sh_next;
         if (load) begin
            cnt_reg <= CNT_W'(FRAME_W - 1);
         end else if (shift && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
         end
      end
   end

   assign out_bit = sh_reg[FRAME_W-1];
   assign count   = cnt_reg;
   assign last    = (cnt_reg == '0);

endmodule

// File: rtl/fsmd_1010_tx.sv
// 1010-preamble serial frame transmitter: preamble, payload MSB-first, optional even parity.
// Optional parity bit is compiled in with `define FSMD_TX_PARITY_EN.
module fsmd_1010_tx #(
   parameter int               DATA_W   = fsmd_1010_pkg::DATA_W,
   parameter int               PRE_W    = fsmd_1010_pkg::PRE_W,
   parameter logic [PRE_W-1:0] PREAMBLE = fsmd_1010_pkg::PREAMBLE
) (
   input  logic                 clk,
   input  logic                 reset_n,
   fsmd_1010_tx_if.slave        bus
);
   import fsmd_1010_pkg::*;

   localparam int FRAME_BITS = PRE_W + DATA_W;
   localparam int CNT_BITS   = cnt_width(FRAME_BITS);

   state_t                state_reg;
   logic                  d_out_reg;
   logic                  frame_reg;
   logic                  busy_reg;
   logic                  done_reg;
`ifdef FSMD_TX_PARITY_EN
   logic                  par_reg;
`endif

   logic                  load;
   logic                  shift;
   logic [FRAME_BITS-1:0] load_word;
   logic                  next_bit;
   logic [CNT_BITS-1:0]   count;
   logic                  last;

   // The first preamble bit goes straight to d_out at acceptance, so the shifter
   // is loaded already advanced by one position.
   assign load_word = {PREAMBLE[PRE_W-2:0], bus.data_in, 1'b0};
   assign load      = (state_reg == S_IDLE) && bus.start;
   assign shift     = (state_reg == S_PRE) || ((state_reg == S_DATA) && !last);

   fsmd_1010_shreg #(
      .FRAME_W (FRAME_BITS),
      .CNT_W   (CNT_BITS)
   ) u_shreg (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (load),
      .shift     (shift),
      .load_word (load_word),
      .out_bit   (next_bit),
      .count     (count),
      .last      (last)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg <= S_IDLE;
         d_out_reg <= 1'b0;
         frame_reg <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
`ifdef FSMD_TX_PARITY_EN
         par_reg   <= 1'b0;
`endif
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (bus.start) begin
                  state_reg <= S_PRE;
                  d_out_reg <= PREAMBLE[PRE_W-1];
                  frame_reg <= 1'b1;
                  busy_reg  <= 1'b1;
`ifdef FSMD_TX_PARITY_EN
                  par_reg   <= ^bus.data_in;
`endif
               end
            end
            S_PRE: begin
               d_out_reg <= next_bit;
               // Remaining count equals DATA_W exactly when the payload MSB is next.
               if (count == CNT_BITS'(DATA_W)) begin
                  state_reg <= S_DATA;
               end
            end
            S_DATA: begin
               if (!last) begin
                  d_out_reg <= next_bit;
               end else begin
`ifdef FSMD_TX_PARITY_EN
                  state_reg <= S_PAR;
                  d_out_reg <= par_reg;
`else
                  state_reg <= S_IDLE;
                  d_out_reg <= 1'b0;
                  frame_reg <= 1'b0;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
`endif
               end
            end
`ifdef FSMD_TX_PARITY_EN
            S_PAR: begin
               state_reg <= S_IDLE;
               d_out_reg <= 1'b0;
               frame_reg <= 1'b0;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b1;
            end
`endif
            default: begin
               state_reg <= S_IDLE;
               d_out_reg <= 1'b0;
               frame_reg <= 1'b0;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.d_out = d_out_reg;
   assign bus.frame = frame_reg;
   assign bus.busy  = busy_reg;
   assign bus.done  = done_reg;

endmodule

// File: tb/tb_fsmd_1010_tx.sv
// Self-checking bench for fsmd_1010_tx: queue-based frame model plus directed literal checks.
module tb_fsmd_1010_tx;
   import fsmd_1010_pkg::*;

`ifdef FSMD_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   // Cycle index of the done pulse, counted from the acceptance cycle T0.
   localparam int D = PRE_W + DATA_W + 1 + P;

   bit   clk;
   logic reset_n;
   bit   chk_en;
   int   errors;
   int   checks;

   fsmd_1010_tx_if #(.DATA_W(DATA_W)) bus ();

   fsmd_1010_tx dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h required %0h at %0t", name, got, want, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Model: an accepted frame becomes a queue of line bits; one bit leaves per clock,
   // and the clock after the queue empties carries the done pulse.
   bit exp_d, exp_f, exp_b, exp_dn;
   bit q[$];
   bit acc;

   always @(posedge clk) begin
      if (!reset_n) begin
         q.delete();
         exp_d = 0; exp_f = 0; exp_b = 0; exp_dn = 0;
      end else begin
         acc = !exp_b && (bus.start === 1'b1);
         if (q.size() > 0) begin
            exp_d = q.pop_front(); exp_f = 1; exp_b = 1; exp_dn = 0;
         end else begin
            exp_dn = exp_b; exp_d = 0; exp_f = 0; exp_b = 0;
         end
         if (acc) begin
            for (int i = PRE_W - 1; i >= 0; i--) q.push_back(PREAMBLE[i]);
            for (int j = DATA_W - 1; j >= 0; j--) q.push_back(bus.data_in[j]);
`ifdef FSMD_TX_PARITY_EN
            q.push_back(^bus.data_in);
`endif
            exp_d = q.pop_front(); exp_f = 1; exp_b = 1; exp_dn = 0;
            $display("tx frame accepted data=%04h at %0t", bus.data_in, $time);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_d_out", 32'(bus.d_out), 32'(exp_d));
         chk("model_frame", 32'(bus.frame), 32'(exp_f));
         chk("model_busy",  32'(bus.busy),  32'(exp_b));
         chk("model_done",  32'(bus.done),  32'(exp_dn));
      end
   end

   logic [19:0] vec;
   logic [15:0] w1, w2, w3;
   logic [3:0]  pre;

   initial begin
      reset_n = 1'b0; bus.start = 1'b1; bus.data_in = 16'h0;
      @(posedge clk);
      chk_en = 1;

      // 1: reset held with start high
      for (int k = 0; k < 2; k++) begin
         tick();
         chk("t1_reset_outs", 32'({bus.d_out, bus.frame, bus.busy, bus.done}), 32'h0);
      end
      reset_n = 1'b1; bus.start = 1'b0;
      repeat (3) tick();

      // 2: single frame A5C3
      bus.data_in = 16'hA5C3; bus.start = 1'b1;
      vec = '0;
      for (int k = 1; k <= D + 1; k++) begin
         tick();
         if (k == 1) bus.start = 1'b0;
         if (k <= 20) begin
            vec = {vec[18:0], bus.d_out};
            chk("t2_frame_high", 32'(bus.frame), 32'h1);
         end
         if (k == D - 1) chk("t2_no_early_done", 32'(bus.done), 32'h0);
         if (k == D) chk("t2_done", 32'(bus.done), 32'h1);
`ifdef FSMD_TX_PARITY_EN
         if (k == 21) chk("t2_parity_a5c3", 32'(bus.d_out), 32'h0);
`endif
      end
      chk("t2_bits", 32'(vec), 32'hAA5C3);
      repeat (2) tick();

      // 3+4: start held, data changed mid-frame, then back-to-back frame 0F0F
      bus.data_in = 16'hA5C3; bus.start = 1'b1;
      w1 = '0; w2 = '0; w3 = '0; pre = '0;
      for (int k = 1; k <= 3 * D + 2; k++) begin
         tick();
         if (k == 8) bus.data_in = 16'hFFFF;
         if (k == D + 5) bus.data_in = 16'h0F0F;
         if (k == 2 * D + 1) bus.start = 1'b0;
         if (k >= 5 && k <= 20) w1 = {w1[14:0], bus.d_out};
         if (k >= D + 5 && k <= D + 20) w2 = {w2[14:0], bus.d_out};
         if (k >= 2 * D + 5 && k <= 2 * D + 20) w3 = {w3[14:0], bus.d_out};
         if (k >= 2 * D + 1 && k <= 2 * D + 4) pre = {pre[2:0], bus.d_out};
         if (k == D + 1) chk("t3_restart_bit", 32'({bus.d_out, bus.frame}), 32'h3);
      end
      chk("t3_first_payload", 32'(w1), 32'hA5C3);
      chk("t3_second_payload", 32'(w2), 32'hFFFF);
      chk("t4_preamble", 32'(pre), 32'hA);
      chk("t4_third_payload", 32'(w3), 32'h0F0F);
      repeat (2) tick();

      // 5: abort by reset mid-frame, then a fresh frame
      bus.data_in = 16'h1234; bus.start = 1'b1;
      for (int k = 1; k <= 12 + D + 2; k++) begin
         tick();
         if (k == 1) bus.start = 1'b0;
         if (k == 10) reset_n = 1'b0;
         if (k == 11) begin
            chk("t5_abort_outs", 32'({bus.d_out, bus.frame, bus.busy, bus.done}), 32'h0);
            reset_n = 1'b1;
         end
         if (k == 12) begin
            chk("t5_no_done", 32'(bus.done), 32'h0);
            bus.data_in = 16'hBEEF; bus.start = 1'b1;
         end
         if (k == 13) begin
            chk("t5_restart", 32'({bus.d_out, bus.frame, bus.busy}), 32'h7);
            bus.start = 1'b0;
         end
         if (k == 12 + D) chk("t5_done", 32'(bus.done), 32'h1);
      end
      repeat (2) tick();

      // 6: payload 0001, LSB last (and parity 1 when compiled in)
      bus.data_in = 16'h0001; bus.start = 1'b1;
      for (int k = 1; k <= D + 1; k++) begin
         tick();
         if (k == 1) bus.start = 1'b0;
         if (k == 20) chk("t6_lsb", 32'(bus.d_out), 32'h1);
`ifdef FSMD_TX_PARITY_EN
         if (k == 21) chk("t6_parity_bit", 32'({bus.d_out, bus.frame}), 32'h3);
`endif
         if (k == D) chk("t6_done", 32'({bus.done, bus.d_out}), 32'h2);
      end
      repeat (2) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
